cpu_bus_arbiter: RTL and testbench
==================================

// Module: cpu_bus_arbiter
// PURPOSE
//  Sits between the SM83 core's memory port and the system bus. Owns HRAM (FF80-FFFE), the
//  OAM DMA register (FF46) and the OAM DMA engine; shares the bus between CPU and DMA,
//  blocking CPU non-HRAM accesses while a DMA transfer owns the bus.
// PARAMETERS
//  DMA_LEN       160  bytes per OAM DMA transfer (index 0..DMA_LEN-1)
//  START_MCYCLES 1    M-cycles between the FF46 write and the first transfer
// PORTS
//  clk            in   1   system clock (4 MHz T-cycles)
//  reset          in   1   synchronous, active-high
//  cpu_addr       in   16  CPU memory address
//  cpu_enable     in   1   CPU access request
//  cpu_write      in   1   CPU write enable
//  cpu_wdata      in   8   CPU write data
//  cpu_rdata      out  8   read data returned to CPU
//  bus_addr       out  16  system bus address
//  bus_enable     out  1   system bus access enable
//  bus_write      out  1   system bus write enable
//  bus_wdata      out  8   system bus write data
//  bus_rdata      in   8   system bus read data
//  oam_addr       out  8   OAM write index from DMA
//  oam_wdata      out  8   OAM write data (= bus_rdata)
//  oam_write      out  1   one-clk OAM write strobe
//  dma_active     out  1   high while DMA owns the bus
// BEHAVIOUR
//  - Internal 2-bit phase counter, reset to 0 with reset; aligns with CPU t_cycle (same reset).
//    All state updates, HRAM/FF46 writes and oam_write happen at phase 3 only.
//  - Reset: state IDLE, idx 0, dma_src 0x00, phase 0, oam_write 0, dma_active 0; HRAM not cleared.
//  - Decode: HRAM = FF80-FFFE, served internally (comb read); FF46 read returns dma_src; both
//    never reach the bus (bus_enable 0). All else forwarded: bus_* = cpu_*, cpu_rdata = bus_rdata.
//  - FSM IDLE -> START (after FF46 write) -> ACTIVE; START lasts START_MCYCLES; ACTIVE one
//    M-cycle per byte, idx 0..DMA_LEN-1; after idx DMA_LEN-1 -> IDLE.
//  - ACTIVE cycle: bus_addr={src_hi,idx}, bus_enable 1, bus_write 0; oam_addr=idx,
//    oam_wdata=bus_rdata, oam_write pulses at phase 3; dma_active=1. START does not block CPU.
//  - Blocking (ACTIVE only): CPU non-HRAM, non-FF46 reads return 0xFF, writes dropped.
//  - FF46 write at M-cycle N -> START N+1 -> ACTIVE N+2..N+161 -> IDLE N+162 (defaults).
//  - FF46 write during START/ACTIVE (incl. last byte): restart wins; new src, idx 0, -> START;
//    dma_active drops for START cycles, no OAM write in them.
//  - src_hi 8 bits; idx 8 bits, never exceeds DMA_LEN-1; bus address never wraps.
//  - Reset mid-transfer: IDLE on next clk, oam_write never pulses after reset.
// CONFIGURATION
//  OAM_DMA_ECHO_MIRROR_EN defined: src_hi >= 0xE0 is used as src_hi-0x20 (echo -> WRAM).
//  Undefined: src_hi used verbatim. FF46 readback is always the written value.
// STRUCTURE
//  Package cpu_bus_pkg: dma_state_e {DmaIdle,DmaStart,DmaActive}, ADDR_DMA=16'hFF46,
//  HRAM_BASE=16'hFF80, HRAM_LAST=16'hFFFE, OPEN_BUS=8'hFF.
//  Sub-module hram: 127x8 array, comb read, write at phase 3; rest is FSM plus muxes.
// TESTING
//  1 Idle: CPU read C000, bus_rdata=0x3C -> bus_addr C000, bus_enable 1, cpu_rdata 0x3C.
//  2 Write 0x5A to FF80, read FF80 -> cpu_rdata 0x5A, bus_enable 0 both cycles.
//  3 Write 0xC1 to FF46 -> 1 M-cycle gap, 160 cycles bus_addr C100..C19F, oam_addr 00..9F,
//    160 oam_write pulses, dma_active high 160 M-cycles; FF46 reads 0xC1.
//  4 During DMA: read 8000 -> 0xFF; write C000 dropped; FF80 read OK; bus shows DMA addr.
//  5 Write 0xD0 to FF46 at idx 50 -> START, then bus_addr D000, oam_addr 00; 160 more bytes.
//  6 Reset at idx 80 -> dma_active 0, no oam_write; FF46 reads 0x00. With
//    OAM_DMA_ECHO_MIRROR_EN, write 0xE3 -> bus_addr C300 first; without -> E300.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types, address map and DMA source mapping (OAM_DMA_ECHO_MIRROR_EN)
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        DmaIdle,
        DmaStart,
        DmaActive
    } dma_state_e;

    localparam logic [15:0] ADDR_DMA  = 16'hFF46;
    localparam logic [15:0] HRAM_BASE = 16'hFF80;
    localparam logic [15:0] HRAM_LAST = 16'hFFFE;
    localparam logic [7:0]  OPEN_BUS  = 8'hFF;

    // Echo RAM (E000-FDFF) shadows WRAM, so the DMA can fetch from the WRAM copy.
    function automatic logic [7:0] dma_src_map(input logic [7:0] src);
`ifdef OAM_DMA_ECHO_MIRROR_EN
        dma_src_map = (src >= 8'hE0) ? (src - 8'h20) : src;
`else
        dma_src_map = src;
`endif
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter_hram.sv
// rtl/cpu_bus_arbiter_hram.sv - 127x8 high RAM, combinational read, phase-qualified write
module cpu_bus_arbiter_hram (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:126];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - CPU/OAM-DMA bus arbiter owning HRAM and FF46 (OAM_DMA_ECHO_MIRROR_EN)
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int DMA_LEN       = 160,
    parameter int START_MCYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_write,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
    localparam logic [7:0] LAST_START = 8'(START_MCYCLES - 1);

    logic [1:0] phase;
    logic       phase3;
    dma_state_e state, state_nx;
    logic [7:0] idx, idx_nx;
    logic [7:0] dma_src, dma_src_nx;
    logic [7:0] start_cnt, start_cnt_nx;
    logic       hram_hit, dma_reg_hit, dma_reg_wr, hram_wr, dma_on;
    logic [7:0] hram_rdata;

    assign phase3      = (phase == 2'd3);
    assign hram_hit    = (cpu_addr >= HRAM_BASE) && (cpu_addr <= HRAM_LAST);
    assign dma_reg_hit = (cpu_addr == ADDR_DMA);
    assign dma_reg_wr  = cpu_enable && cpu_write && dma_reg_hit && phase3;
    assign hram_wr     = cpu_enable && cpu_write && hram_hit && phase3;
    assign dma_on      = (state == DmaActive);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= 2'd0;
            state     <= DmaIdle;
            idx       <= 8'd0;
            dma_src   <= 8'h00;
            start_cnt <= 8'd0;
        end else begin
            phase     <= phase + 2'd1;
            state     <= state_nx;
            idx       <= idx_nx;
            dma_src   <= dma_src_nx;
            start_cnt <= start_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        dma_src_nx   = dma_src;
        start_cnt_nx = start_cnt;
        if (phase3) begin
            case (state)
                DmaStart: begin
                    if (start_cnt == LAST_START) begin
                        state_nx = DmaActive;
                        idx_nx   = 8'd0;
                    end else begin
                        start_cnt_nx = start_cnt + 8'd1;
                    end
                end
                DmaActive: begin
                    if (idx == LAST_IDX) begin
                        state_nx = DmaIdle;
                        idx_nx   = 8'd0;
                    end else begin
                        idx_nx = idx + 8'd1;
                    end
                end
                default: begin
                    state_nx = DmaIdle;
                end
            endcase
            // A new FF46 write always restarts, even on the final byte.
            if (dma_reg_wr) begin
                state_nx     = DmaStart;
                dma_src_nx   = cpu_wdata;
                idx_nx       = 8'd0;
                start_cnt_nx = 8'd0;
            end
        end
    end

    always_comb begin
        bus_addr   = cpu_addr;
        bus_enable = cpu_enable;
        bus_write  = cpu_write;
        bus_wdata  = cpu_wdata;
        if (dma_on) begin
            bus_addr   = {dma_src_map(dma_src), idx};
            bus_enable = 1'b1;
            bus_write  = 1'b0;
            bus_wdata  = 8'h00;
        end else if (hram_hit || dma_reg_hit) begin
            bus_enable = 1'b0;
            bus_write  = 1'b0;
        end

        if (hram_hit) begin
            cpu_rdata = hram_rdata;
        end else if (dma_reg_hit) begin
            cpu_rdata = dma_src;
        end else if (dma_on) begin
            cpu_rdata = OPEN_BUS;
        end else begin
            cpu_rdata = bus_rdata;
        end
    end

    assign oam_addr   = idx;
    assign oam_wdata  = bus_rdata;
    assign oam_write  = dma_on && phase3 && !reset;
    assign dma_active = dma_on;

    cpu_bus_arbiter_hram u_hram (
        .clk   (clk),
        .we    (hram_wr),
        .addr  (cpu_addr[6:0]),
        .wdata (cpu_wdata),
        .rdata (hram_rdata)
    );

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - self-checking bench for cpu_bus_arbiter with a schedule-based DMA model
module tb_cpu_bus_arbiter;

    localparam int DMA_LEN       = 160;
    localparam int START_MCYCLES = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_enable = 1'b0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic        bus_enable;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_write;
    logic        dma_active;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(.DMA_LEN(DMA_LEN), .START_MCYCLES(START_MCYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_enable (cpu_enable),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .bus_addr   (bus_addr),
        .bus_enable (bus_enable),
        .bus_write  (bus_write),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .oam_addr   (oam_addr),
        .oam_wdata  (oam_wdata),
        .oam_write  (oam_write),
        .dma_active (dma_active)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the DMA is described by when the last FF46 write happened,
    // so the byte index of any M-cycle follows from plain subtraction.
    int         mcyc = 0;
    int         wr_m = 0;
    bit         wr_valid = 0;
    logic [7:0] src_m = 8'h00;
    logic [7:0] hram_m [127];
    bit         hram_v [127];
    int         oam_count = 0;
    int         act_count = 0;

    typedef struct {
        logic [15:0] a;
        bit          en;
        bit          wr;
        logic [7:0]  wd;
        logic [7:0]  brd;
        logic [7:0]  exp_rd;
        bit          exp_ben;
        bit          chk_rd;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (mcycle %0d)", name, act, exp, mcyc);
        end
    endtask

    function automatic logic [7:0] eff_src(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_MIRROR_EN
        eff_src = (s >= 8'hE0) ? s - 8'h20 : s;
`else
        eff_src = s;
`endif
    endfunction

    task automatic run_m(input logic [15:0] a, input bit en, input bit wr, input logic [7:0] wd,
                         input logic [7:0] brd, output logic [7:0] rd_s, output logic ben_s);
        int  k;
        bit  act, hr, fr;
        int  hi;
        k  = mcyc - wr_m - 1 - START_MCYCLES;
        act = wr_valid && (k >= 0) && (k < DMA_LEN);
        hr = (a >= 16'hFF80) && (a <= 16'hFFFE);
        fr = (a == 16'hFF46);
        hi = int'(a[6:0]);
        rd_s  = 8'h00;
        ben_s = 1'b0;
        cpu_addr   = a;
        cpu_enable = en;
        cpu_write  = wr;
        cpu_wdata  = wd;
        bus_rdata  = brd;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            chk("dma_active", dma_active, act);
            chk("bus_enable", bus_enable, act ? 1 : ((hr || fr) ? 0 : en));
            chk("bus_addr", bus_addr, act ? {eff_src(src_m), 8'(k)} : a);
            if (act) chk("bus_write_dma", bus_write, 0);
            else if (!hr && !fr) begin
                chk("bus_write", bus_write, wr);
                chk("bus_wdata", bus_wdata, wd);
            end
            if (en && !wr) begin
                if (hr) begin
                    if (hram_v[hi]) chk("hram_rd", cpu_rdata, hram_m[hi]);
                end else if (fr) chk("ff46_rd", cpu_rdata, src_m);
                else if (act) chk("blocked_rd", cpu_rdata, 8'hFF);
                else chk("bus_rd", cpu_rdata, brd);
            end
            if (p == 3 && act) begin
                chk("oam_write", oam_write, 1);
                chk("oam_addr", oam_addr, k);
                chk("oam_wdata", oam_wdata, brd);
            end else begin
                chk("oam_write_idle", oam_write, 0);
            end
            if (oam_write) oam_count++;
            if (p == 3) begin
                rd_s  = cpu_rdata;
                ben_s = bus_enable;
            end
            @(posedge clk);
            #1;
        end
        if (act) act_count++;
        if (en && wr && fr) begin
            wr_valid = 1;
            wr_m     = mcyc;
            src_m    = wd;
        end
        if (en && wr && hr) begin
            hram_m[hi] = wd;
            hram_v[hi] = 1;
        end
        mcyc++;
    endtask

    task automatic idle(input int n);
        logic [7:0] rd;
        logic       ben;
        for (int i = 0; i < n; i++) begin
            run_m(16'h0000, 0, 0, 8'h00, 8'($urandom), rd, ben);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        cpu_enable = 1'b0;
        cpu_write  = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_dma_active", dma_active, 0);
        chk("reset_oam_write", oam_write, 0);
        @(posedge clk);
        #1;
        chk("reset_oam_write2", oam_write, 0);
        reset    = 1'b0;
        wr_valid = 0;
        src_m    = 8'h00;
        mcyc     = 0;
    endtask

    function automatic int cur_idx();
        cur_idx = mcyc - wr_m - 1 - START_MCYCLES;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  rd;
        logic        ben;
        logic [15:0] ra;
        bit          ren, rwr;
        int          sel;

        for (int i = 0; i < 127; i++) hram_v[i] = 0;

        tbl[0] = '{16'hFF46, 1, 0, 8'h00, 8'h99, 8'h00, 0, 1};
        tbl[1] = '{16'hC000, 1, 0, 8'h00, 8'h3C, 8'h3C, 1, 1};
        tbl[2] = '{16'hFF80, 1, 1, 8'h5A, 8'h11, 8'h00, 0, 0};
        tbl[3] = '{16'hFF80, 1, 0, 8'h00, 8'h22, 8'h5A, 0, 1};
        tbl[4] = '{16'hFFFE, 1, 1, 8'hA5, 8'h33, 8'h00, 0, 0};
        tbl[5] = '{16'hFFFE, 1, 0, 8'h00, 8'h44, 8'hA5, 0, 1};
        tbl[6] = '{16'hFFFF, 1, 0, 8'h00, 8'h77, 8'h77, 1, 1};
        tbl[7] = '{16'hFF7F, 1, 0, 8'h00, 8'h12, 8'h12, 1, 1};
        tbl[8] = '{16'hD123, 1, 1, 8'h9C, 8'h00, 8'h00, 1, 0};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            run_m(tbl[i].a, tbl[i].en, tbl[i].wr, tbl[i].wd, tbl[i].brd, rd, ben);
            if (tbl[i].chk_rd) chk("tbl_rdata", rd, tbl[i].exp_rd);
            chk("tbl_bus_enable", ben, tbl[i].exp_ben);
        end

        // Full transfer from C100.
        oam_count = 0;
        act_count = 0;
        run_m(16'hFF46, 1, 1, 8'hC1, 8'h00, rd, ben);
        idle(1);
        chk("first_dma_addr", bus_addr, 16'hC100);
        idle(DMA_LEN + 2);
        chk("oam_pulses", oam_count, DMA_LEN);
        chk("active_mcycles", act_count, DMA_LEN);
        run_m(16'hFF46, 1, 0, 8'h00, 8'h00, rd, ben);
        chk("ff46_readback", rd, 8'hC1);

        // CPU accesses while the DMA owns the bus.
        run_m(16'hFF46, 1, 1, 8'hC2, 8'h00, rd, ben);
        idle(START_MCYCLES);
        run_m(16'h8000, 1, 0, 8'h00, 8'h55, rd, ben);
        chk("blocked_8000", rd, 8'hFF);
        run_m(16'hC000, 1, 1, 8'h66, 8'h00, rd, ben);
        chk("blocked_write_bus_en", bus_write, 0);
        run_m(16'hFF80, 1, 0, 8'h00, 8'h00, rd, ben);
        chk("hram_during_dma", rd, 8'h5A);

        // Restart at idx 50.
        while (cur_idx() < 50) idle(1);
        run_m(16'hFF46, 1, 1, 8'hD0, 8'h00, rd, ben);
        oam_count = 0;
        idle(START_MCYCLES);
        chk("restart_addr", bus_addr, 16'hD000);
        chk("restart_oam_addr", oam_addr, 8'h00);
        idle(DMA_LEN + 3);
        chk("restart_pulses", oam_count, DMA_LEN);

        // Reset in the middle of byte 80.
        run_m(16'hFF46, 1, 1, 8'hC4, 8'h00, rd, ben);
        while (cur_idx() < 80) idle(1);
        @(posedge clk);
        @(posedge clk);
        #1;
        oam_count = 0;
        do_reset();
        run_m(16'hFF46, 1, 0, 8'h00, 8'h00, rd, ben);
        chk("ff46_after_reset", rd, 8'h00);
        idle(4);
        chk("no_oam_after_reset", oam_count, 0);

        // Echo source.
        run_m(16'hFF46, 1, 1, 8'hE3, 8'h00, rd, ben);
        idle(START_MCYCLES);
`ifdef OAM_DMA_ECHO_MIRROR_EN
        chk("echo_src_addr", bus_addr, 16'hC300);
`else
        chk("echo_src_addr", bus_addr, 16'hE300);
`endif
        idle(DMA_LEN + 2);

        // Random traffic against the model.
        for (int i = 0; i < 700; i++) begin
            sel = $urandom_range(0, 19);
            if (sel < 5) ra = 16'hFF80 + 16'($urandom_range(0, 126));
            else if (sel < 7) ra = 16'hFF46;
            else if (sel == 7) ra = 16'hFFFF;
            else ra = 16'($urandom);
            ren = ($urandom_range(0, 4) != 0);
            rwr = ren && ($urandom_range(0, 2) == 0);
            if (ra == 16'hFF46 && rwr && ($urandom_range(0, 5) != 0)) rwr = 0;
            run_m(ra, ren, rwr, 8'($urandom), 8'($urandom), rd, ben);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
